// File: rtl/shift_left_iter_pkg.sv
// Shared defaults and FSM state encoding for the iterative left shifter.
package shift_left_iter_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNTW_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_left_iter_shamt_clamp.sv
// Clamps the raw shift amount to min(b, WIDTH) so it fits the shift counter.
module shift_left_iter_shamt_clamp #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic [WIDTH-1:0] b,
    output logic [CNTW-1:0]  n
);

    localparam logic [WIDTH-1:0] LIMIT   = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  N_LIMIT = CNTW'(WIDTH);

    // Full-width compare, so high bits such as 16'h8001 saturate rather than wrap.
    assign n = (b >= LIMIT) ? N_LIMIT : b[CNTW-1:0];

endmodule

// File: rtl/shift_left_iter.sv
// Multi-cycle logical shift-left: one bit per clock, with a START/BUSY/DONE handshake.
module shift_left_iter
    import shift_left_iter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] o,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  n;
    logic             accept;

    shift_left_iter_shamt_clamp #(
        .WIDTH(WIDTH),
        .CNTW (CNTW)
    ) u_shamt_clamp (
        .b(b),
        .n(n)
    );

    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = start ? ST_SHIFT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too, because o is architecturally
    // visible and must read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            o   <= '0;
        end else if (accept) begin
            acc <= a;
            cnt <= n;
        end else if (state == ST_SHIFT) begin
            if (cnt != '0) begin
                acc <= {acc[WIDTH-2:0], 1'b0};
                cnt <= cnt - CNTW'(1);
            end else begin
                o <= acc;
            end
        end
    end

endmodule

// File: tb/tb_shift_left_iter.sv
// Self-checking bench: directed vector table, random ops vs. arithmetic model, corner sequences.
module tb_shift_left_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    shift_left_iter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .o    (o),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_o;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: a logical left shift by b with anything >= 16 giving zero.
    function automatic logic [15:0] model_o(input logic [15:0] av, input logic [15:0] bv);
        int amt = int'(bv);
        if (amt >= 16) return 16'h0000;
        return 16'((32'(av) << amt) & 32'hFFFF);
    endfunction

    function automatic int model_lat(input logic [15:0] bv);
        int amt = int'(bv);
        return ((amt >= 16) ? 16 : amt) + 1;
    endfunction

    // Wait for done after the accepting edge; check latency, busy span and result.
    task automatic wait_result(input string name, input logic [15:0] exp_o, input int exp_lat);
        int lat = 0;
        int busy_cycles = 0;
        int overlap = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
            if (busy && done) overlap++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy cycles"}, busy_cycles, exp_lat);
        check({name, " o"}, o, exp_o);
        check({name, " busy&done"}, overlap, 0);
    endtask

    task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] exp_o, input int exp_lat);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av;
        b = 16'h0003;
        wait_result(name, exp_o, exp_lat);
    endtask

    vec_t vecs[7];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("reset o", o, 16'h0000);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{16'h0001, 16'h0000, 16'h0001, 1};
        vecs[1] = '{16'h0001, 16'h0001, 16'h0002, 2};
        vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFE, 2};
        vecs[3] = '{16'hFFFF, 16'h000F, 16'h8000, 16};
        vecs[4] = '{16'hFFFF, 16'h0010, 16'h0000, 17};
        vecs[5] = '{16'hFFFF, 16'h8001, 16'h0000, 17};
        vecs[6] = '{16'hA5A5, 16'h0004, 16'h5A50, 5};

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_o, vecs[i].exp_lat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse", i), done, 0);
            check($sformatf("vec%0d idle busy", i), busy, 0);
            check($sformatf("vec%0d o held", i), o, vecs[i].exp_o);
        end

        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = (i % 5 == 4) ? 16'($urandom) : 16'($urandom_range(0, 18));
            run_op($sformatf("rand%0d", i), ra, rb, model_o(ra, rb), model_lat(rb));
        end

        // START held through SHIFT with changing operands must be ignored.
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'h0008;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h1234;
        b = 16'h0002;
        wait_result("start held", 16'hFF00, 9);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("start held idle done", done, 0);
        check("start held o kept", o, 16'hFF00);

        // Back-to-back: a new START in the DONE cycle is accepted.
        run_op("b2b first", 16'hFFFF, 16'h0003, 16'hFFF8, 4);
        a = 16'h00F0;
        b = 16'h0004;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b busy after accept", busy, 1);
        wait_result("b2b second", 16'h0F00, 5);

        // Asynchronous reset mid-shift abandons the operation.
        @(negedge clk);
        a = 16'h1234;
        b = 16'h0008;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async reset o", o, 16'h0000);
        check("async reset busy", busy, 0);
        check("async reset done", done, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("no done during reset", seen, 0);
        end
        rst_n = 1'b1;
        run_op("after reset", 16'h1234, 16'h0008, 16'h3400, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
